// File: rtl/core_rst_seq.sv
// Core reset sequencer: holds purst for a fixed time after configuration completes, then
// releases the core and drives a glitch-filtered, minimum-width set/reset from an async request.
module core_rst_seq #(
  parameter int unsigned PURST_CYCLES = 16,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILT_CYCLES  = 4,
  parameter int unsigned SR_MIN_PULSE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_done,
  input  logic sr_req,
  output logic purst,
  output logic s_r,
  output logic ready
);

  localparam int unsigned HoldW  = $clog2(PURST_CYCLES + 1);
  localparam int unsigned FiltW  = $clog2(FILT_CYCLES + 1);
  localparam int unsigned PulseW = $clog2(SR_MIN_PULSE + 1);

  // Hold counter runs 0..PURST_CYCLES so RUN is entered PURST_CYCLES+1 edges after cfg_done.
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(PURST_CYCLES);
  localparam logic [FiltW-1:0]  FiltLast = FiltW'(FILT_CYCLES - 1);
  localparam logic [PulseW-1:0] PulseMin = PulseW'(SR_MIN_PULSE);
  localparam logic [PulseW-1:0] PulseOne = PulseW'(1);

  typedef enum logic [1:0] {
    StCfgWait,
    StPurstHold,
    StRun
  } state_e;

  // Request synchronizer.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sr_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sr_req};
    end
  end

  assign sr_sync = sync_q[SYNC_STAGES-1];

  // Glitch filter: output follows the synchronized value only after it has differed for
  // FILT_CYCLES consecutive cycles; any agreement clears the count.
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sr_sync != filt_q) begin
      if (filt_cnt_q == FiltLast) begin
        filt_d = sr_sync;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Sequencer with registered outputs.
  state_e            state_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [PulseW-1:0] pulse_cnt_q;
  logic              purst_q, ready_q, s_r_q;
  logic              sr_hold, sr_next;

  // A raised s_r is kept up until it has been high SR_MIN_PULSE cycles.
  assign sr_hold = s_r_q && (pulse_cnt_q < PulseMin);
  assign sr_next = filt_q || sr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCfgWait;
      hold_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      purst_q     <= 1'b1;
      ready_q     <= 1'b0;
      s_r_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StCfgWait: begin
          s_r_q       <= 1'b0;
          pulse_cnt_q <= '0;
          if (cfg_done) begin
            state_q    <= StPurstHold;
            hold_cnt_q <= '0;
          end
        end
        StPurstHold: begin
          if (!cfg_done) begin
            state_q    <= StCfgWait;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HoldLast) begin
            state_q <= StRun;
            purst_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!cfg_done) begin
            state_q     <= StCfgWait;
            hold_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            purst_q     <= 1'b1;
            ready_q     <= 1'b0;
            s_r_q       <= 1'b0;
          end else begin
            s_r_q <= sr_next;
            if (!sr_next) begin
              pulse_cnt_q <= '0;
            end else if (!s_r_q) begin
              pulse_cnt_q <= PulseOne;
            end else if (pulse_cnt_q != PulseMin) begin
              pulse_cnt_q <= pulse_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= StCfgWait;
          hold_cnt_q  <= '0;
          pulse_cnt_q <= '0;
          purst_q     <= 1'b1;
          ready_q     <= 1'b0;
          s_r_q       <= 1'b0;
        end
      endcase
    end
  end

  assign purst = purst_q;
  assign ready = ready_q;
  assign s_r   = s_r_q;

endmodule
